// File: rtl/send_unit.sv
// SEND instruction engine: streams a block of data-memory words onto the
// outbound valid/ready link and stalls the PU while a transfer is in flight.
module send_unit #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          send,
  input  logic [DW-1:0] addr_in,
  input  logic [DW-1:0] size_in,
  input  logic [PW-1:0] port_in,
  output logic          stall,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [PW-1:0] out_port,
  output logic          out_last,
  output logic          done
);

  typedef enum logic [1:0] {IDLE, RD, LD, XFER} state_t;

  state_t        state;
  logic [AW-1:0] cur_addr;
  logic [DW-1:0] remain;
  logic          unused_addr_hi;

  // Only the low AW bits of the ra value address data memory.
  assign unused_addr_hi = ^addr_in[DW-1:AW];

  assign stall = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remain    <= '0;
      out_port  <= '0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
    end else begin
      done  <= 1'b0;
      rd_en <= 1'b0;
      case (state)
        IDLE: begin
          if (send) begin
            if (size_in == '0) begin
              done <= 1'b1;
            end else begin
              cur_addr <= addr_in[AW-1:0];
              remain   <= size_in;
              out_port <= port_in;
              rd_en    <= 1'b1;
              rd_addr  <= addr_in[AW-1:0];
              state    <= RD;
            end
          end
        end
        // read issued this cycle; data arrives next cycle
        RD: state <= LD;
        LD: begin
          out_data  <= rd_data;
          out_valid <= 1'b1;
          out_last  <= (remain == DW'(1));
          state     <= XFER;
        end
        // word held stable until the receiver accepts it
        XFER: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (remain == DW'(1)) begin
              out_last <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              remain   <= remain - DW'(1);
              cur_addr <= cur_addr + AW'(1);
              rd_en    <= 1'b1;
              rd_addr  <= cur_addr + AW'(1);
              state    <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_send_unit.sv
// Bench for send_unit: data-memory model, handshake monitor and a
// transfer-level reference model of the words each SEND should produce.
module tb_send_unit;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          send = 1'b0;
  logic [DW-1:0] addr_in = '0;
  logic [DW-1:0] size_in = '0;
  logic [PW-1:0] port_in = '0;
  logic          stall;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [PW-1:0] out_port;
  logic          out_last;
  logic          done;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int exp_done = 0;
  bit rnd_ready = 1'b0;

  logic [DW-1:0] dmem [0:(1<<AW)-1];

  logic [DW-1:0] hs_data[$];
  logic          hs_last[$];
  logic [PW-1:0] hs_port[$];
  logic [AW-1:0] rd_q[$];
  logic [DW-1:0] exp_data[$];
  logic          exp_last[$];
  logic [PW-1:0] exp_port[$];
  logic [AW-1:0] exp_addr[$];

  send_unit #(.DW(DW), .AW(AW), .PW(PW)) dut (
    .clk(clk), .rst_n(rst_n), .send(send), .addr_in(addr_in),
    .size_in(size_in), .port_in(port_in), .stall(stall), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_port(out_port),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= dmem[rd_addr];

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        hs_data.push_back(out_data);
        hs_last.push_back(out_last);
        hs_port.push_back(out_port);
      end
      if (rd_en) rd_q.push_back(rd_addr);
      if (done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_send(input logic [DW-1:0] a, input logic [DW-1:0] s, input logic [PW-1:0] p);
    send = 1'b1; addr_in = a; size_in = s; port_in = p;
    for (int i = 0; i < int'(s); i++) begin
      logic [AW-1:0] ad;
      ad = a[AW-1:0] + AW'(i);
      exp_addr.push_back(ad);
      exp_data.push_back(dmem[ad]);
      exp_last.push_back(i == int'(s) - 1);
      exp_port.push_back(p);
    end
    @(posedge clk); #1;
    send = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    int sbad = 0;
    while (!done && n < budget) begin
      if (!stall) sbad++;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_stall_during"}, sbad, 0);
    check({tag, "_stall_at_done"}, stall, 0);
    exp_done++;
    @(posedge clk); #1;
    check({tag, "_done_one_cycle"}, done, 0);
  endtask

  task automatic cmp_xfer(input string tag);
    check({tag, "_words"}, hs_data.size(), exp_data.size());
    check({tag, "_reads"}, rd_q.size(), exp_addr.size());
    for (int i = 0; i < hs_data.size() && i < exp_data.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), hs_data[i], exp_data[i]);
      check($sformatf("%s_last%0d", tag, i), hs_last[i], exp_last[i]);
      check($sformatf("%s_port%0d", tag, i), hs_port[i], exp_port[i]);
    end
    for (int i = 0; i < rd_q.size() && i < exp_addr.size(); i++)
      check($sformatf("%s_rdaddr%0d", tag, i), rd_q[i], exp_addr[i]);
    check({tag, "_done_count"}, done_cnt, exp_done);
    hs_data.delete(); hs_last.delete(); hs_port.delete(); rd_q.delete();
    exp_data.delete(); exp_last.delete(); exp_port.delete(); exp_addr.delete();
  endtask

  initial begin
    int n;
    int bad;
    logic [DW-1:0] d0;

    for (int i = 0; i < (1 << AW); i++) dmem[i] = DW'($urandom);

    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_port", out_port, 0);
    check("rst_out_last", out_last, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic 3-word transfer
    dmem[8'h10] = 16'hAAAA; dmem[8'h11] = 16'hBBBB; dmem[8'h12] = 16'hCCCC;
    out_ready = 1'b1;
    do_send(16'h0010, 16'd3, 4'h5);
    check("basic_stall_after_send", stall, 1);
    wait_done("basic", 50);
    cmp_xfer("basic");

    // backpressure
    out_ready = 1'b0;
    do_send(16'h0030, 16'd2, 4'h9);
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("bp_first_valid", out_valid, 1);
    d0 = out_data;
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (out_data !== d0 || out_valid !== 1'b1) bad++;
    end
    check("bp_hold_stable", bad, 0);
    check("bp_no_second_read", rd_q.size(), 1);
    out_ready = 1'b1;
    wait_done("bp", 50);
    cmp_xfer("bp");

    // zero size
    do_send(16'h0044, 16'd0, 4'h3);
    check("zero_done_next", done, 1);
    check("zero_stall", stall, 0);
    exp_done++;
    @(posedge clk); #1;
    check("zero_done_once", done, 0);
    check("zero_stall_after", stall, 0);
    repeat (3) @(posedge clk);
    #1;
    cmp_xfer("zero");

    // address wrap with random backpressure
    rnd_ready = 1'b1;
    do_send(16'h00FE, 16'd3, 4'hC);
    wait_done("wrap", 200);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    cmp_xfer("wrap");

    // reset mid-transfer
    do_send(16'h0050, 16'd4, 4'h7);
    n = 0;
    while (hs_data.size() < 2 && n < 50) begin @(negedge clk); #1; n++; end
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    check("mid_third_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_valid_drop", out_valid, 0);
    check("mid_stall_drop", stall, 0);
    check("mid_last_drop", out_last, 0);
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_done", done_cnt, exp_done);
    check("mid_words", hs_data.size(), 2);
    for (int i = 0; i < 2 && i < hs_data.size(); i++)
      check($sformatf("mid_data%0d", i), hs_data[i], exp_data[i]);
    hs_data.delete(); hs_last.delete(); hs_port.delete(); rd_q.delete();
    exp_data.delete(); exp_last.delete(); exp_port.delete(); exp_addr.delete();
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    do_send(16'h0077, 16'd1, 4'h2);
    wait_done("post_rst", 50);
    cmp_xfer("post_rst");

    // ignored send during active transfer
    do_send(16'h0060, 16'd2, 4'hA);
    send = 1'b1; addr_in = 16'h0090; size_in = 16'd9; port_in = 4'h6;
    @(posedge clk); #1;
    send = 1'b0;
    wait_done("ign", 60);
    cmp_xfer("ign");

    // randomized transfers
    rnd_ready = 1'b1;
    for (int t = 0; t < 8; t++) begin
      do_send(DW'($urandom), DW'($urandom_range(1, 6)), PW'($urandom));
      wait_done($sformatf("rnd%0d", t), 300);
      out_ready = 1'b1;
      cmp_xfer($sformatf("rnd%0d", t));
    end
    rnd_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
